reset_seq: RTL

Parametrised multi-channel reset sequencer. One asynchronous active-high reset source plus a filtered synchronous reset request drive CN ordered reset outputs. All outputs assert together; they release one at a time, channel 0 first, spaced DLY clock cycles apart. The block sits at the top of the clock domain and feeds reset to the subsystems that must come out of reset in a fixed order (for example clock and PLL logic, then the bus, then peripherals).

---
 rtl/reset_seq_if.sv | 8 +
 rtl/reset_seq.sv | 69 ++++++
 2 files changed

// File: rtl/reset_seq_if.sv
// reset_seq_if: request input and ordered reset outputs of the reset sequencer
interface reset_seq_if #(parameter int CN = 4);
    logic          req_i;
    logic [CN-1:0] rst_o;
    logic          busy_o;
    modport master (output req_i, input rst_o, busy_o);
    modport slave  (input req_i, output rst_o, busy_o);
endinterface

// File: rtl/reset_seq.sv
// reset_seq: filtered-request, multi-channel reset sequencer releasing channels in order DLY cycles apart
module reset_seq #(
    parameter int CN  = 4,
    parameter int DLY = 16,
    parameter int FN  = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    reset_seq_if.slave   bus
);
    localparam int CW = $clog2(DLY + 1);
    localparam int IW = $clog2(CN + 1);
    localparam int FW = $clog2(FN + 1);
    localparam logic [CW-1:0] DLY_M = CW'(DLY - 1);
    localparam logic [FW-1:0] FN_M  = FW'(FN - 1);
    localparam logic [FW-1:0] FN_W  = FW'(FN);
    localparam logic [IW-1:0] LAST  = IW'(CN - 1);
    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [CN-1:0] rst_q, rst_n;
    logic          busy_q, acc, step;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= HOLD;
            cnt    <= '0;
            fcnt   <= '0;
            idx    <= '0;
            rst_q  <= '1;
            busy_q <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            fcnt   <= fcnt_n;
            idx    <= idx_n;
            rst_q  <= rst_n;
            busy_q <= |rst_n;
        end
    end
    always_comb begin
        fcnt_n  = bus.req_i ? ((fcnt == FN_W) ? fcnt : fcnt + 1'b1) : '0;
        acc     = bus.req_i && (fcnt == FN_M);
        step    = (state == RELEASE) || (state == HOLD && !bus.req_i);
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rst_n   = rst_q;
        if (acc) begin
            state_n = HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            rst_n   = '1;
        end else if (step) begin
            // idx is 0 in HOLD, so one release path covers both HOLD and RELEASE
            if (cnt == DLY_M) begin
                cnt_n   = '0;
                rst_n   = rst_q & ~(CN'(1) << idx);
                idx_n   = idx + 1'b1;
                state_n = (idx == LAST) ? RUN : RELEASE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end
    assign bus.rst_o  = rst_q;
    assign bus.busy_o = busy_q;
endmodule
